digit_update_arbiter: RTL
=========================

DIGIT_UPDATE_ARBITER -- requirements
Module: digit_update_arbiter

Interface
REQ-001 SHALL have parameter: VSYNC_ACTIVE_LOW, default 1, 1 = vsync pulse is low, 0 = high.
REQ-002 SHALL have parameter: MAX_VAL, default 9, largest digit value stored; range 0..15.
REQ-003 SHALL have port: Clock  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-low reset; sampled on rising edge of Clock.
REQ-005 SHALL have port: vsync  in  1  frame sync from the timing generator, same clock domain.
REQ-006 SHALL have port: a_req  in  1  requester A write request.
REQ-007 SHALL have port: a_idx  in  2  requester A digit index 0..3.
REQ-008 SHALL have port: a_val  in  4  requester A digit value.
REQ-009 SHALL have port: a_ack  out  1  one-cycle grant acknowledge to A.
REQ-010 SHALL have ports: b_req, b_idx, b_val, b_ack, identical in width and meaning to the A ports, serving requester B.
REQ-011 SHALL have port: digits  out  16  active bank, digit i on bits [4i+3:4i], registered.
REQ-012 SHALL have port: dirty  out  1  high while the shadow bank holds uncommitted writes.
REQ-013 SHALL have port: commit_pulse  out  1  high for exactly the one cycle in which the shadow bank is copied to the active bank.

Function
REQ-014 SHALL hold two 4x4-bit banks: shadow (written by requesters) and active (drives digits).
REQ-015 SHALL register vsync into vsync_q; frame_start = vsync at active level AND vsync_q at inactive level.
REQ-016 SHALL implement FSM with states IDLE, PENDING, COMMIT; dirty = (state == PENDING).
REQ-017 IDLE -> PENDING on any grant; IDLE ignores frame_start (no commit, no pulse).
REQ-018 PENDING -> COMMIT on frame_start; no grant issued in the frame_start cycle; further grants keep PENDING.
REQ-019 COMMIT: active <= shadow, commit_pulse = 1, no grant; always -> IDLE next cycle.
REQ-020 Eligibility: requester X is eligible when x_req = 1, x_ack = 0 in the current cycle, and state is not COMMIT and frame_start is not true in PENDING.
REQ-021 At most one grant per cycle; one eligible requester -> granted; both eligible -> requester named by the round-robin pointer is granted.
REQ-022 Pointer = A after reset; after a cycle in which both were eligible, pointer moves to the requester not granted; unchanged otherwise.
REQ-023 Grant in cycle N: shadow[x_idx] written at end of cycle N; x_ack = 1 during cycle N+1 only.
REQ-024 Value rule: x_val > MAX_VAL is written as MAX_VAL (saturate); x_val <= MAX_VAL is written unchanged.
REQ-025 Requester protocol: hold req/idx/val stable until ack is seen; may drop req or present a new request in the ack cycle (new request is eligible the cycle after ack).
REQ-026 Repeated writes to the same index before commit: last granted write wins.
REQ-027 digits SHALL change only in the cycle after COMMIT; never mid-frame.
REQ-028 vsync held at active level for many cycles SHALL produce exactly one frame_start.

Reset
REQ-029 reset = 0 at a rising edge SHALL set: shadow and active banks = 0, digits = 16'h0000, a_ack = b_ack = 0, commit_pulse = 0, state IDLE, pointer A, vsync_q = inactive level.
REQ-030 Reset mid-operation SHALL discard pending shadow writes and any ack that would have issued; no commit_pulse follows.
REQ-031 While reset = 0, requests SHALL be ignored and no ack issued.

Verification
REQ-032 Single write: a_req, a_idx=2, a_val=7 -> a_ack one cycle later, dirty=1, digits still 0000; vsync pulse -> commit_pulse once, digits = 16'h0700, dirty=0.
REQ-033 Contention: a_req and b_req held from reset, idx 0 and 1, val 3 and 5 -> A acked first, B acked next, then after vsync digits = 16'h0053.
REQ-034 Saturation: b_val = 4'hF to idx 3 with MAX_VAL=9 -> digits[15:12] = 9 after commit.
REQ-035 Collision: request presented in the same cycle as frame_start in PENDING -> not granted that cycle or the COMMIT cycle, acked afterwards, committed at the next frame, not this one.
REQ-036 Idle frames and long vsync: vsync pulses with no writes -> commit_pulse stays 0; vsync held active 800 cycles after a write -> exactly one commit_pulse.
REQ-037 Reset mid-operation: write idx 0 val 4, reset = 0 one cycle before vsync -> digits stay 16'h0000, no commit_pulse, dirty = 0.

Source files
------------

// File: rtl/digit_update_arbiter.sv
// Two-requester round-robin writer into a 4-digit shadow bank. The shadow bank is
// copied to the displayed (active) bank only at the next frame start, so digits never tear.
module digit_update_arbiter #(
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int MAX_VAL          = 9
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        a_req,
  input  logic [1:0]  a_idx,
  input  logic [3:0]  a_val,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [1:0]  b_idx,
  input  logic [3:0]  b_val,
  output logic        b_ack,
  output logic [15:0] digits,
  output logic        dirty,
  output logic        commit_pulse
);

  localparam logic       VS_ACT   = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic       VS_INACT = ~VS_ACT;
  localparam logic [3:0] MAX_Q    = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;          // 0 = A has priority, 1 = B
  logic        vsync_q;
  logic        a_ack_q, b_ack_q;
  logic        dirty_q, commit_q;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;

  logic        frame_start_s, block_s;
  logic        a_elig_s, b_elig_s, a_gnt_s, b_gnt_s, wr_en_s;
  logic [1:0]  wr_idx_s;
  logic [3:0]  wr_val_s;

  function automatic logic [3:0] sat_val(input logic [3:0] v);
    if (v > MAX_Q) begin
      return MAX_Q;
    end else begin
      return v;
    end
  endfunction

  // Frame-start detect, eligibility and round-robin grant selection.
  always_comb begin
    frame_start_s = (vsync == VS_ACT) && (vsync_q == VS_INACT);
    block_s       = (state_q == S_COMMIT) || ((state_q == S_PENDING) && frame_start_s);
    a_elig_s      = a_req && !a_ack_q && !block_s;
    b_elig_s      = b_req && !b_ack_q && !block_s;
    a_gnt_s       = 1'b0;
    b_gnt_s       = 1'b0;
    ptr_d         = ptr_q;
    if (a_elig_s && b_elig_s) begin
      if (ptr_q == 1'b0) begin
        a_gnt_s = 1'b1;
        ptr_d   = 1'b1;
      end else begin
        b_gnt_s = 1'b1;
        ptr_d   = 1'b0;
      end
    end else begin
      a_gnt_s = a_elig_s;
      b_gnt_s = b_elig_s;
    end
    wr_en_s  = a_gnt_s || b_gnt_s;
    wr_idx_s = a_gnt_s ? a_idx : b_idx;
    wr_val_s = a_gnt_s ? a_val : b_val;
  end

  // Shadow write and commit FSM next-state.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;
    if (wr_en_s) begin
      shadow_d[{wr_idx_s, 2'b00} +: 4] = sat_val(wr_val_s);
    end else begin
      shadow_d = shadow_q;
    end
    case (state_q)
      S_IDLE: begin
        if (wr_en_s) begin
          state_d = S_PENDING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        if (frame_start_s) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_PENDING;
        end
      end
      S_COMMIT: begin
        state_d  = S_IDLE;
        active_d = shadow_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; dirty and commit_pulse are registered decodes of the next state.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      vsync_q  <= VS_INACT;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      dirty_q  <= 1'b0;
      commit_q <= 1'b0;
      shadow_q <= 16'h0000;
      active_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vsync_q  <= vsync;
      a_ack_q  <= a_gnt_s;
      b_ack_q  <= b_gnt_s;
      dirty_q  <= (state_d == S_PENDING);
      commit_q <= (state_d == S_COMMIT);
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign digits       = active_q;
  assign dirty        = dirty_q;
  assign commit_pulse = commit_q;

endmodule
